seg7_dec_display: RTL
=====================

Name: seg7_dec_display

Overview:
- Output-side counterpart to the key/switch input path: takes an 8-bit binary result (e.g. the adder sum) and drives decimal digits on active-low 7-segment HEX displays.
- Converts binary to BCD sequentially with shift-and-add-3 (double dabble), one bit per clock.
- Registers BCD and segment outputs, with optional leading-zero blanking.
- Load/busy/done handshake and a one-entry pending buffer, so upstream can strobe a new value at any time.

Parameters:
WIDTH, 8, binary input width.
DIGITS, 3, number of decimal digits. Must satisfy 10^DIGITS > 2^WIDTH - 1.
BLANK_LZ, 1, 1 = blank leading zeros (digit 0 is never blanked); 0 = show all digits.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
load  in  1  single-cycle strobe; samples value on the same edge
value  in  WIDTH  unsigned binary to display
busy  out  1  high while a conversion is in progress (state != IDLE)
done  out  1  one-cycle pulse when bcd/hex update
bcd  out  4*DIGITS  registered BCD result, digit 0 in [3:0]
hex  out  7*DIGITS  registered active-low segments, digit i in [7i+6:7i], bit order g..a = [6:0]

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, busy=0, done=0, bcd=0, pending flag=0.
  - Every hex digit = 7'h7F (all off).
  - Applies immediately and aborts any conversion in flight.
  - No done pulse follows reset.
- States:
  - IDLE: wait for load.
  - CONV: WIDTH shift cycles.
  - SHOW: commit outputs.
- IDLE, load=1 at edge N:
  - Capture value into the shift register.
  - Clear the BCD accumulator and the bit counter.
  - Go to CONV; busy goes high after edge N.
- CONV, each edge N+1..N+WIDTH:
  - Add 3 to every BCD nibble >= 5.
  - Then shift {bcd_acc, shift_reg} left by 1.
  - Counter increments; on iteration WIDTH go to SHOW.
- SHOW, edge N+WIDTH+1:
  - bcd <= accumulator; hex <= encoded digits; done <= 1 for exactly one cycle.
  - If pending=1: start a new conversion from the pending value (same as IDLE+load), clear pending, and go to CONV.
  - Otherwise go to IDLE.
- Latency: load edge to the hex/done edge is WIDTH+1 cycles (9 by default).
- busy:
  - High from after edge N through the SHOW edge.
  - Stays high across back-to-back conversions driven by pending.
- load while busy:
  - Value stored in a one-entry pending buffer and pending flag set.
  - A later load before the buffer drains overwrites it (newest wins).
  - No load is ever lost except through overwrite.
- load on the SHOW edge itself:
  - Treated as pending.
  - The new conversion starts at that same edge; the overwrite rule still applies.
- Segment encoding (active-low, hex values):
  - 0 = 40, 1 = 79, 2 = 24, 3 = 30, 4 = 19.
  - 5 = 12, 6 = 02, 7 = 78, 8 = 00, 9 = 10.
  - Blank = 7F.
- Leading-zero blanking (BLANK_LZ=1):
  - Digit i>0 is blanked iff it and all higher digits are 0.
  - Inner zeros are displayed.
  - bcd is never blanked.
- hex and bcd hold their values between updates; they change only on the SHOW edge.

Test Plan:
- Reset then idle 20 cycles -> hex = 7F_7F_7F (digit2..0), bcd = 0, busy = 0, done never asserted.
- load with value=0 at edge N -> at edge N+9: done=1 for one cycle, bcd=000, hex digit2=7F, digit1=7F, digit0=40. Repeat with BLANK_LZ=0 -> 40_40_40.
- load 255 -> bcd=0x255, hex=24_12_12. load 100 -> bcd=0x100, hex=79_40_40 (inner zeros shown). load 7 -> hex=7F_7F_78.
- load 42 at N; load 13 at N+3; load 99 at N+5 -> first done at N+9 shows 042; busy stays high; second done at N+18 shows 099 (13 overwritten); exactly 2 done pulses.
- load 200, then pull rst_n low at N+4 (between clock edges) -> outputs go to reset values immediately; no done pulse. After release, load 5 -> bcd=0x005 after 9 cycles.
- load held high for 30 cycles with an incrementing value -> done pulses every 9 cycles. Each displayed value equals the value at the load edge that started that conversion; busy never drops.

Source files
------------

// File: rtl/seg7_dec_display.sv
// seg7_dec_display: sequential binary-to-BCD (double dabble) driving registered active-low 7-segment digits
// with a one-entry pending buffer so upstream may strobe load at any time.
module seg7_dec_display #(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 3,
  parameter bit BLANK_LZ = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic [WIDTH-1:0]      value_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic [7*DIGITS-1:0]   hex_o
);
  localparam int BW = 4*DIGITS;
  localparam int CW = $clog2(WIDTH+1);
  typedef enum logic [1:0] {IDLE, CONV, SHOW} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d, pval_q, pval_d;
  logic [BW-1:0] acc_q, acc_d, adj, bcd_q, bcd_d;
  logic [7*DIGITS-1:0] hex_q, hex_d, enc;
  logic [CW-1:0] cnt_q, cnt_d;
  logic pend_q, pend_d, done_q, done_d, lz;

  function automatic logic [6:0] seg(input logic [3:0] n);
    case (n)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // lz walks from the top digit down and stays set only while every digit so far is zero
  always_comb begin
    adj = acc_q;
    enc = '1;
    lz  = BLANK_LZ;
    for (int i = DIGITS-1; i >= 0; i--) begin
      adj[4*i+:4] = acc_q[4*i+:4] >= 4'd5 ? acc_q[4*i+:4] + 4'd3 : acc_q[4*i+:4];
      lz = lz && acc_q[4*i+:4] == 4'd0 && i > 0;
      enc[7*i+:7] = lz ? 7'h7F : seg(acc_q[4*i+:4]);
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    pval_d  = pval_q;
    bcd_d   = bcd_q;
    hex_d   = hex_q;
    done_d  = 1'b0;
    if (state_q == CONV) begin
      {acc_d, sh_d} = {adj[BW-2:0], sh_q, 1'b0};
      cnt_d   = cnt_q + 1'b1;
      state_d = cnt_q == CW'(WIDTH-1) ? SHOW : CONV;
      pend_d  = pend_q | load_i;
      pval_d  = load_i ? value_i : pval_q;
    end else if (state_q == SHOW) begin
      bcd_d   = acc_q;
      hex_d   = enc;
      done_d  = 1'b1;
      pend_d  = 1'b0;
      state_d = (load_i || pend_q) ? CONV : IDLE;
    end else begin
      state_d = load_i ? CONV : IDLE;
    end
    // a load on the SHOW edge is newer than the buffered value, so it wins
    if (state_d == CONV && state_q != CONV) begin
      sh_d  = load_i ? value_i : pval_q;
      acc_d = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sh_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      pval_q  <= '0;
      bcd_q   <= '0;
      hex_q   <= '1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      pval_q  <= pval_d;
      bcd_q   <= bcd_d;
      hex_q   <= hex_d;
      done_q  <= done_d;
    end
  end

  assign busy_o = state_q != IDLE;
  assign done_o = done_q;
  assign bcd_o  = bcd_q;
  assign hex_o  = hex_q;
endmodule
